// File: rtl/mem_bus_ctrl_if.sv
// MEM-stage request/response channel between the pipeline and the memory bus controller.
// The pipeline is the master and the controller is the slave.
interface mem_bus_ctrl_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    logic              memread_i;
    logic              memwrite_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic              ack_o;
    logic              stall_o;

    modport master (
        output memread_i, memwrite_i, addr_i, wdata_i,
        input  rdata_o, ack_o, stall_o
    );

    modport slave (
        input  memread_i, memwrite_i, addr_i, wdata_i,
        output rdata_o, ack_o, stall_o
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Sequences one MEM-stage load/store onto the shared Ram1 bus (data SRAM or board UART),
// stalling the pipeline until the access completes.
module mem_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES    = 1,
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
    input  logic         clk,
    input  logic         rst,
    mem_bus_ctrl_if.slave mbus,
    output logic [17:0]  Ram1Addr,
    inout  wire  [15:0]  Ram1Data,
    output logic         Ram1OE,
    output logic         Ram1WE,
    output logic         Ram1EN,
    output logic         wrn,
    output logic         rdn,
    input  logic         tbre,
    input  logic         tsre,
    input  logic         data_ready
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned RAM_AW = 18;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SRAM_RD, SRAM_WR, SRAM_WR_HOLD, UART_RD, UART_WR, UART_WR_HOLD, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic oe_q, oe_d, we_q, we_d, en_q, en_d;
    logic rdn_q, rdn_d, wrn_q, wrn_d, drv_q, drv_d, ack_q, ack_d;

    logic req, is_wr, hit_data, hit_stat, cnt_last;

    assign req      = mbus.memread_i | mbus.memwrite_i;
    assign is_wr    = mbus.memwrite_i;
    assign hit_data = (mbus.addr_i == UART_DATA_ADDR);
    assign hit_stat = (mbus.addr_i == UART_STAT_ADDR);
    assign cnt_last = (cnt_q == CNT_LAST);

    // State and datapath register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            en_q    <= 1'b1;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            drv_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            en_q    <= en_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            drv_q   <= drv_d;
            ack_q   <= ack_d;
        end
    end

    // Next state, strobe-width counter and address/data capture
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = mbus.addr_i;
                    wdata_d = mbus.wdata_i;
                    if (hit_stat) begin
                        state_d = DONE;
                        if (!is_wr) rdata_d = {14'b0, data_ready, tbre & tsre};
                    end else if (hit_data) begin
                        state_d = is_wr ? UART_WR : UART_RD;
                    end else begin
                        state_d = is_wr ? SRAM_WR : SRAM_RD;
                    end
                end
            end
            SRAM_RD, UART_RD: begin
                if (cnt_last) begin
                    rdata_d = Ram1Data;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SRAM_WR: begin
                if (cnt_last) state_d = SRAM_WR_HOLD;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            UART_WR: begin
                if (cnt_last) state_d = UART_WR_HOLD;
                else          cnt_d   = cnt_q + CNT_W'(1);
            end
            SRAM_WR_HOLD, UART_WR_HOLD: state_d = DONE;
            DONE:                       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Strobes decoded from the next state so they register glitch-free alongside it
    always_comb begin
        oe_d  = 1'b1;
        we_d  = 1'b1;
        en_d  = 1'b1;
        rdn_d = 1'b1;
        wrn_d = 1'b1;
        drv_d = 1'b0;
        ack_d = 1'b0;
        case (state_d)
            SRAM_RD: begin
                en_d = 1'b0;
                oe_d = 1'b0;
            end
            SRAM_WR: begin
                en_d  = 1'b0;
                we_d  = 1'b0;
                drv_d = 1'b1;
            end
            SRAM_WR_HOLD: begin
                en_d  = 1'b0;
                drv_d = 1'b1;
            end
            UART_RD: rdn_d = 1'b0;
            UART_WR: begin
                wrn_d = 1'b0;
                drv_d = 1'b1;
            end
            UART_WR_HOLD: drv_d = 1'b1;
            DONE:         ack_d = 1'b1;
            default: ;
        endcase
    end

    assign Ram1Addr     = {(RAM_AW - ADDR_W)'(0), addr_q};
    assign Ram1Data     = drv_q ? wdata_q : 'z;
    assign Ram1OE       = oe_q;
    assign Ram1WE       = we_q;
    assign Ram1EN       = en_q;
    assign rdn          = rdn_q;
    assign wrn          = wrn_q;
    assign mbus.rdata_o = rdata_q;
    assign mbus.ack_o   = ack_q;
    // Stall holds through the whole access but drops in DONE so the pipeline moves with ack
    assign mbus.stall_o = (state_q == IDLE) ? req : (state_q != DONE);
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: two instances (1 and 3 wait cycles), each with an SRAM/UART model
// on its Ram1 bus; a monitor tallies strobe activity per access and checks it when ack_o arrives.
module tb_mem_bus_ctrl;
    localparam logic [15:0] UART_RX = 16'h0041;

    typedef struct packed {
        logic [15:0] rdata;
        int          stall;
        int          oe;
        int          we;
        int          en;
        int          rdn;
        int          wrn;
        int          drv;
        logic [15:0] dval;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tbre = 1'b1, tsre = 1'b1, data_ready = 1'b1;

    logic        rd_req   [2];
    logic        wr_req   [2];
    logic [15:0] addr_in  [2];
    logic [15:0] wdata_in [2];

    logic        oe_n [2], we_n [2], en_n [2], rdn_n [2], wrn_n [2];
    logic        ack_n [2], stall_n [2], drv_n [2];
    logic [15:0] rdata_n [2], bus_n [2];
    logic [17:0] addr_n [2];

    int total = 0;
    int bad   = 0;

    exp_t q0 [$];
    exp_t q1 [$];

    int          c_stall [2], c_oe [2], c_we [2], c_en [2], c_rdn [2], c_wrn [2], c_drv [2], c_cfl [2];
    logic [15:0] c_dval  [2];
    logic        prev_ack [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_ctrl_if bus ();
        wire  [15:0] ram1_data;
        logic [17:0] ram1_addr;
        logic        ram1_oe, ram1_we, ram1_en, uwrn, urdn;
        logic [15:0] mem [256];
        logic        mdl_drv;
        logic [15:0] mdl_val;

        assign bus.memread_i  = rd_req[g];
        assign bus.memwrite_i = wr_req[g];
        assign bus.addr_i     = addr_in[g];
        assign bus.wdata_i    = wdata_in[g];

        mem_bus_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .mbus       (bus),
            .Ram1Addr   (ram1_addr),
            .Ram1Data   (ram1_data),
            .Ram1OE     (ram1_oe),
            .Ram1WE     (ram1_we),
            .Ram1EN     (ram1_en),
            .wrn        (uwrn),
            .rdn        (urdn),
            .tbre       (tbre),
            .tsre       (tsre),
            .data_ready (data_ready)
        );

        // Device model: SRAM answers OE&EN, UART answers rdn; undriven bus pulls to all ones
        assign mdl_drv   = (!ram1_oe && !ram1_en) || !urdn;
        assign mdl_val   = !urdn ? UART_RX : mem[ram1_addr[7:0]];
        assign ram1_data = mdl_drv ? mdl_val : 16'hzzzz;
        pullup (ram1_data);

        always @(negedge clk) begin
            if (!ram1_we && !ram1_en) mem[ram1_addr[7:0]] <= ram1_data;
        end

        assign oe_n[g]    = ram1_oe;
        assign we_n[g]    = ram1_we;
        assign en_n[g]    = ram1_en;
        assign rdn_n[g]   = urdn;
        assign wrn_n[g]   = uwrn;
        assign ack_n[g]   = bus.ack_o;
        assign stall_n[g] = bus.stall_o;
        assign rdata_n[g] = bus.rdata_o;
        assign bus_n[g]   = ram1_data;
        assign drv_n[g]   = mdl_drv;
        assign addr_n[g]  = ram1_addr;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] rdata, input int stall, input int oe, input int we,
                                input int en, input int rdn, input int wrn, input int drv,
                                input logic [15:0] dval);
        exp_t e;
        e.rdata = rdata; e.stall = stall; e.oe = oe; e.we = we; e.en = en;
        e.rdn = rdn; e.wrn = wrn; e.drv = drv; e.dval = dval;
        return e;
    endfunction

    task automatic clr(input int k);
        c_stall[k] = 0; c_oe[k] = 0; c_we[k] = 0; c_en[k] = 0;
        c_rdn[k] = 0; c_wrn[k] = 0; c_drv[k] = 0; c_cfl[k] = 0; c_dval[k] = 16'h0;
    endtask

    // Monitor: accumulate per-access activity, compare against the scoreboard on each ack
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                clr(k);
                prev_ack[k] = 1'b0;
            end else begin
                exp_t e;
                if (stall_n[k]) c_stall[k]++;
                if (!oe_n[k])   c_oe[k]++;
                if (!we_n[k])   c_we[k]++;
                if (!en_n[k])   c_en[k]++;
                if (!rdn_n[k])  c_rdn[k]++;
                if (!wrn_n[k])  c_wrn[k]++;
                if (!drv_n[k] && bus_n[k] != 16'hFFFF) begin
                    c_drv[k]++;
                    c_dval[k] = bus_n[k];
                end
                if ((!oe_n[k] || !we_n[k] || !en_n[k]) && (!rdn_n[k] || !wrn_n[k])) c_cfl[k]++;
                if (ack_n[k]) begin
                    chk("ack_width", k, 32'(prev_ack[k]), 32'd0);
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        total++;
                        bad++;
                        $display("FAIL dut%0d unexpected_ack: ack with no pending access at %0t", k, $time);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("rdata",          k, 32'(rdata_n[k]), 32'(e.rdata));
                        chk("stall_cycles",   k, c_stall[k],      e.stall);
                        chk("oe_low",         k, c_oe[k],         e.oe);
                        chk("we_low",         k, c_we[k],         e.we);
                        chk("en_low",         k, c_en[k],         e.en);
                        chk("rdn_low",        k, c_rdn[k],        e.rdn);
                        chk("wrn_low",        k, c_wrn[k],        e.wrn);
                        chk("bus_drive",      k, c_drv[k],        e.drv);
                        if (e.drv != 0) chk("bus_value", k, 32'(c_dval[k]), 32'(e.dval));
                        chk("strobe_overlap", k, c_cfl[k],        0);
                    end
                    clr(k);
                end
                prev_ack[k] = ack_n[k];
            end
        end
    end

    task automatic run_txn(input int k, input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] d, input exp_t e);
        bit seen = 1'b0;
        @(posedge clk); #1;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        rd_req[k] = rd; wr_req[k] = wr; addr_in[k] = a; wdata_in[k] = d;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack_n[k]) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL dut%0d ack_timeout: no ack within 40 cycles for addr %0h", k, a);
        end else begin
            chk("ram1_addr", k, 32'(addr_n[k]), 32'({2'b00, a}));
        end
        @(posedge clk); #1;
        rd_req[k] = 1'b0; wr_req[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_ack;
        for (int k = 0; k < 2; k++) begin
            rd_req[k] = 1'b0; wr_req[k] = 1'b0; addr_in[k] = 16'h0; wdata_in[k] = 16'h0;
        end

        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_strobes", k, 32'({oe_n[k], we_n[k], en_n[k], rdn_n[k], wrn_n[k]}), 32'h1F);
            chk("rst_bus_z",   k, 32'(bus_n[k]),   32'hFFFF);
            chk("rst_addr",    k, 32'(addr_n[k]),  32'h0);
            chk("rst_rdata",   k, 32'(rdata_n[k]), 32'h0);
            chk("rst_ack",     k, 32'(ack_n[k]),   32'h0);
            chk("rst_stall",   k, 32'(stall_n[k]), 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        //           k  rd    wr    addr      wdata          rdata    st oe we en rn wn dv dval
        run_txn(0, 1'b0, 1'b1, 16'h0040, 16'h1234, mk(16'h0000, 3, 0, 1, 2, 0, 0, 2, 16'h1234));
        run_txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, mk(16'h1234, 2, 1, 0, 1, 0, 0, 0, 16'h0000));
        run_txn(0, 1'b1, 1'b0, 16'hBF01, 16'h0000, mk(16'h0003, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
        run_txn(0, 1'b1, 1'b0, 16'hBF00, 16'h0000, mk(16'h0041, 2, 0, 0, 0, 1, 0, 0, 16'h0000));
        run_txn(1, 1'b0, 1'b1, 16'hBF00, 16'h005A, mk(16'h0000, 5, 0, 0, 0, 0, 3, 4, 16'h005A));
        run_txn(0, 1'b1, 1'b1, 16'h0100, 16'hBEEF, mk(16'h0041, 3, 0, 1, 2, 0, 0, 2, 16'hBEEF));
        run_txn(0, 1'b1, 1'b0, 16'h0100, 16'h0000, mk(16'hBEEF, 2, 1, 0, 1, 0, 0, 0, 16'h0000));
        run_txn(0, 1'b0, 1'b1, 16'hBF01, 16'h9999, mk(16'hBEEF, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
        tsre = 1'b0;
        run_txn(1, 1'b1, 1'b0, 16'hBF01, 16'h0000, mk(16'h0002, 1, 0, 0, 0, 0, 0, 0, 16'h0000));
        tsre = 1'b1;
        run_txn(1, 1'b0, 1'b1, 16'h0007, 16'h0F0F, mk(16'h0002, 5, 0, 3, 4, 0, 0, 4, 16'h0F0F));
        run_txn(1, 1'b1, 1'b0, 16'h0007, 16'h0000, mk(16'h0F0F, 4, 3, 0, 3, 0, 0, 0, 16'h0000));
        run_txn(1, 1'b1, 1'b0, 16'hBF00, 16'h0000, mk(16'h0041, 4, 0, 0, 0, 3, 0, 0, 16'h0000));

        // Reset in the middle of an SRAM write on the 3-wait instance
        @(posedge clk); #1;
        wr_req[1] = 1'b1; addr_in[1] = 16'h0020; wdata_in[1] = 16'h7777;
        @(posedge clk); #1;
        chk("midrst_we_active", 1, 32'(we_n[1]), 32'h0);
        rst = 1'b0;
        wr_req[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_strobes", 1, 32'({oe_n[1], we_n[1], en_n[1], rdn_n[1], wrn_n[1]}), 32'h1F);
        chk("midrst_bus_z",   1, 32'(bus_n[1]),   32'hFFFF);
        chk("midrst_ack",     1, 32'(ack_n[1]),   32'h0);
        chk("midrst_stall",   1, 32'(stall_n[1]), 32'h0);
        chk("midrst_rdata",   0, 32'(rdata_n[0]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        seen_ack = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack_n[1]) seen_ack = 1'b1;
        end
        chk("midrst_no_ack", 1, 32'(seen_ack), 32'h0);

        run_txn(1, 1'b1, 1'b0, 16'hBF01, 16'h0000, mk(16'h0003, 1, 0, 0, 0, 0, 0, 0, 16'h0000));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 0, 32'(q0.size() + q1.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
